reg_file_8x16: RTL and testbench
================================

# reg_file_8x16

Eight-entry, 16-bit register file with two registered read ports and one write port; read port A and read port B drive the i0 and i1 inputs of the downstream 16-bit 2-to-1 operand mux. Register r7 doubles as the program counter and auto-increments by 2 when enabled. All state sits in one clock domain with synchronous active-high reset.

## Interface
Parameters:
- NREG, 8, number of registers (fixed at 8; address width 3)
- WIDTH, 16, data width
- PC_IDX, 7, index of the program-counter register
- PC_STEP, 2, PC increment per enabled cycle

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk
- we  input  1  write enable
- wr_addr  input  3  write address
- wr_data  input  16  write data
- rd_addr_a  input  3  read address, port A
- rd_addr_b  input  3  read address, port B
- pc_inc  input  1  increment r7 by PC_STEP this cycle
- rd_data_a  output  16  registered read data, port A (feeds mux i0)
- rd_data_b  output  16  registered read data, port B (feeds mux i1)
- pc_out  output  16  current r7 value, driven directly from the register

## Operation
- State: reg[0..7], each 16 bits; rd_data_a and rd_data_b are output registers.
- Next-value rule per register k, in priority order:
  - reset=1: 0.
  - we=1 and wr_addr==k: wr_data.
  - k==7 and pc_inc=1: reg[7] + 2, truncated to 16 bits (16'hFFFE -> 16'h0000, 16'hFFFF -> 16'h0001).
  - otherwise: hold.
- A write to r7 overrides pc_inc in the same cycle; the increment is dropped, not deferred.
- Read ports use write-first semantics. On each edge, rd_data_x <= next value of reg[rd_addr_x] as defined above. A write, or an r7 increment, is therefore visible on the read port in the same cycle it is committed.
- Both ports may read the same address, including the address being written; both return the same value.
- No register is hardwired. r0 is read/write like the others.
- Reset:
  - On the edge where reset=1, every reg, rd_data_a, rd_data_b and pc_out become 0.
  - we and pc_inc are ignored while reset=1.
  - Reset asserted mid-operation discards any write or increment in that cycle.

## Timing
- Write latency: 1 edge. Data presented at edge N is stored at edge N.
- Read latency: 1 edge. An address presented before edge N produces data on rd_data_x after edge N, held until the next edge.
- Same-cycle write and read of one address: the read returns wr_data after that edge. There is no stale-data cycle and no external forwarding is required.
- pc_out updates with a 1-edge latency relative to we/pc_inc and has no combinational path from the inputs.
- Continuous pc_inc=1 advances r7 by 2 every edge.
- Outputs after reset deasserts: all 0 until the first non-reset edge updates them.

## Test plan
- Reset: preload r0..r7 with nonzero values, assert reset for 1 edge with we=1 and pc_inc=1. Required: all regs, rd_data_a, rd_data_b and pc_out read 16'h0000.
- Write/read all: write r_k = 16'h1000+k for k=0..7. Required: reading them back pairwise (A=k, B=7-k) returns the matching values 1 edge after the address is applied.
- Write-first bypass: we=1, wr_addr=3, wr_data=16'hBEEF, rd_addr_a=rd_addr_b=3, prior r3=16'h0005. Required: rd_data_a = rd_data_b = 16'hBEEF after that same edge.
- PC increment and wrap: write r7=16'hFFFC, then pc_inc=1 for 3 edges. Required: pc_out sequence FFFE, 0000, 0002, and rd_addr_a=7 tracks the same sequence.
- Write beats increment: r7=16'h0010, we=1, wr_addr=7, wr_data=16'h0100, pc_inc=1. Required: pc_out=16'h0100 (not 0102 or 0012); the next edge with pc_inc=1 gives 16'h0102.
- Downstream hookup: connect rd_data_a/b to the 16-bit mux with r1=5 and r2=6 read on ports A and B. Required: mux out=6 for s0=1 and out=5 for s0=0.

Source files
------------

// File: rtl/reg_file_8x16.sv
// Eight-entry register file with two registered write-first read ports.
// r7 doubles as the program counter and advances by PC_STEP when pc_inc is set.
module reg_file_8x16 #(
   parameter int unsigned NREG    = 8,
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned PC_IDX  = 7,
   parameter int unsigned PC_STEP = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [2:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [2:0]       rd_addr_a,
   input  logic [2:0]       rd_addr_b,
   input  logic             pc_inc,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic [WIDTH-1:0] pc_out
);

   logic [WIDTH-1:0] regs [NREG];
   logic [WIDTH-1:0] nxt  [NREG];

   // Next value of every register; the read ports sample this, giving write-first reads.
   always_comb begin
      for (int unsigned k = 0; k < NREG; k++) begin
         nxt[k] = regs[k];
         if (reset)
            nxt[k] = '0;
         else if (we && (wr_addr == 3'(k)))
            nxt[k] = wr_data;
         else if ((k == PC_IDX) && pc_inc)
            nxt[k] = regs[k] + WIDTH'(PC_STEP);
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < NREG; k++)
         regs[k] <= nxt[k];
      if (reset) begin
         rd_data_a <= '0;
         rd_data_b <= '0;
      end else begin
         rd_data_a <= nxt[rd_addr_a];
         rd_data_b <= nxt[rd_addr_b];
      end
   end

   assign pc_out = regs[PC_IDX];

endmodule

// File: tb/tb_reg_file_8x16.sv
// Directed self-checking bench for reg_file_8x16.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_reg_file_8x16;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic [2:0]  rd_addr_a;
   logic [2:0]  rd_addr_b;
   logic        pc_inc;
   logic [15:0] rd_data_a;
   logic [15:0] rd_data_b;
   logic [15:0] pc_out;
   logic        s0;
   logic [15:0] mux_out;

   int checks   = 0;
   int failures = 0;

   reg_file_8x16 #(.NREG(8), .WIDTH(16), .PC_IDX(7), .PC_STEP(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .pc_inc    (pc_inc),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .pc_out    (pc_out)
   );

   // Downstream operand mux: i0 = port A, i1 = port B.
   assign mux_out = s0 ? rd_data_b : rd_data_a;

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
      we = 1'b1; wr_addr = a; wr_data = d;
      step();
      we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; we = 1'b0; pc_inc = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr_a = 3'd0; rd_addr_b = 3'd7; s0 = 1'b0;
      step(); step();
      reset = 1'b0;
      checks++;
      if (rd_data_a !== 16'h0000 || rd_data_b !== 16'h0000 || pc_out !== 16'h0000) begin
         failures++;
         $display("FAIL initial_reset: a=%h b=%h pc=%h required 0000", rd_data_a, rd_data_b, pc_out);
      end
      for (int k = 0; k < 8; k++) write_reg(3'(k), 16'hA000 + 16'(k) + 16'h0100);
      // reset with write and increment pending must discard both
      reset = 1'b1; we = 1'b1; wr_addr = 3'd2; wr_data = 16'hFFFF; pc_inc = 1'b1;
      rd_addr_a = 3'd7; rd_addr_b = 3'd2;
      step();
      reset = 1'b0; we = 1'b0; pc_inc = 1'b0;
      checks++;
      if (rd_data_a !== 16'h0000 || rd_data_b !== 16'h0000 || pc_out !== 16'h0000) begin
         failures++;
         $display("FAIL reset_midop: a=%h b=%h pc=%h required 0000", rd_data_a, rd_data_b, pc_out);
      end
      for (int k = 0; k < 4; k++) begin
         rd_addr_a = 3'(k); rd_addr_b = 3'(k + 4);
         step();
         checks++;
         if (rd_data_a !== 16'h0000 || rd_data_b !== 16'h0000) begin
            failures++;
            $display("FAIL reset_clears r%0d/r%0d: a=%h b=%h required 0000", k, k + 4, rd_data_a, rd_data_b);
         end
      end
   endtask

   task automatic test_write_read();
      logic [15:0] ea, eb;
      for (int k = 0; k < 8; k++) write_reg(3'(k), 16'h1000 + 16'(k));
      for (int k = 0; k < 8; k++) begin
         rd_addr_a = 3'(k); rd_addr_b = 3'(7 - k);
         ea = 16'h1000 + 16'(k);
         eb = 16'h1000 + 16'(7 - k);
         step();
         checks++;
         if (rd_data_a !== ea || rd_data_b !== eb) begin
            failures++;
            $display("FAIL read_pair k=%0d: a=%h b=%h required a=%h b=%h", k, rd_data_a, rd_data_b, ea, eb);
         end
      end
   endtask

   task automatic test_bypass();
      rd_addr_a = 3'd3; rd_addr_b = 3'd3;
      write_reg(3'd3, 16'h0005);
      checks++;
      if (rd_data_a !== 16'h0005 || rd_data_b !== 16'h0005) begin
         failures++;
         $display("FAIL bypass_prior: a=%h b=%h required 0005", rd_data_a, rd_data_b);
      end
      write_reg(3'd3, 16'hBEEF);
      checks++;
      if (rd_data_a !== 16'hBEEF || rd_data_b !== 16'hBEEF) begin
         failures++;
         $display("FAIL bypass_same_edge: a=%h b=%h required beef", rd_data_a, rd_data_b);
      end
   endtask

   task automatic test_pc_increment();
      logic [15:0] exp_seq [3];
      exp_seq[0] = 16'hFFFE; exp_seq[1] = 16'h0000; exp_seq[2] = 16'h0002;
      rd_addr_a = 3'd7; rd_addr_b = 3'd0;
      write_reg(3'd7, 16'hFFFC);
      // pc_out must not react combinationally to pc_inc
      pc_inc = 1'b1;
      #1;
      checks++;
      if (pc_out !== 16'hFFFC) begin
         failures++;
         $display("FAIL pc_no_comb_path: pc=%h required fffc", pc_out);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (pc_out !== exp_seq[i] || rd_data_a !== exp_seq[i]) begin
            failures++;
            $display("FAIL pc_inc step %0d: pc=%h a=%h required %h", i, pc_out, rd_data_a, exp_seq[i]);
         end
      end
      pc_inc = 1'b0;
      write_reg(3'd7, 16'hFFFF);
      pc_inc = 1'b1;
      step();
      pc_inc = 1'b0;
      checks++;
      if (pc_out !== 16'h0001) begin
         failures++;
         $display("FAIL pc_wrap_odd: pc=%h required 0001", pc_out);
      end
      step();
      checks++;
      if (pc_out !== 16'h0001 || rd_data_a !== 16'h0001) begin
         failures++;
         $display("FAIL pc_hold: pc=%h a=%h required 0001", pc_out, rd_data_a);
      end
   endtask

   task automatic test_write_beats_inc();
      rd_addr_a = 3'd7;
      write_reg(3'd7, 16'h0010);
      we = 1'b1; wr_addr = 3'd7; wr_data = 16'h0100; pc_inc = 1'b1;
      step();
      we = 1'b0;
      checks++;
      if (pc_out !== 16'h0100 || rd_data_a !== 16'h0100) begin
         failures++;
         $display("FAIL write_beats_inc: pc=%h a=%h required 0100", pc_out, rd_data_a);
      end
      step();
      pc_inc = 1'b0;
      checks++;
      if (pc_out !== 16'h0102) begin
         failures++;
         $display("FAIL inc_after_write: pc=%h required 0102", pc_out);
      end
   endtask

   task automatic test_mux_hookup();
      write_reg(3'd1, 16'h0005);
      write_reg(3'd2, 16'h0006);
      rd_addr_a = 3'd1; rd_addr_b = 3'd2;
      step();
      s0 = 1'b1;
      #1;
      checks++;
      if (mux_out !== 16'h0006) begin
         failures++;
         $display("FAIL mux_s0_1: out=%h required 0006", mux_out);
      end
      s0 = 1'b0;
      #1;
      checks++;
      if (mux_out !== 16'h0005) begin
         failures++;
         $display("FAIL mux_s0_0: out=%h required 0005", mux_out);
      end
   endtask

   task automatic test_r0_and_unrelated_hold();
      rd_addr_a = 3'd0; rd_addr_b = 3'd6;
      write_reg(3'd0, 16'h1234);
      checks++;
      if (rd_data_a !== 16'h1234 || rd_data_b !== 16'h1006) begin
         failures++;
         $display("FAIL r0_writable: a=%h b=%h required a=1234 b=1006", rd_data_a, rd_data_b);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_r0_and_unrelated_hold();
      test_pc_increment();
      test_write_beats_inc();
      test_mux_hookup();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
